// File: rtl/xsim_dma_arb_pkg.sv
// Shared types and limits for the Xsim DMA arbiter.
package xsim_dma_arb_pkg;

  localparam int MAX_CLIENTS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] handle;
    logic [31:0] data;
  } dma_cmd_t;

endpackage

// File: rtl/xsim_rr_pick.sv
// Rotate-priority picker: the first asserted request at or after ptr
// (wrapping modulo N) wins.
module xsim_rr_pick
  import xsim_dma_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the closest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    cand  = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      cand  = IDX_W'((int'(ptr) + i) % N);
      found = req[cand] ? 1'b1 : found;
      idx   = req[cand] ? cand : idx;
    end
  end

endmodule

// File: rtl/xsim_dma_arbiter.sv
// Round-robin arbiter sharing one simulated DMA engine among several
// clients; one transaction in flight, reads routed back to their owner.
module xsim_dma_arbiter
  import xsim_dma_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_CLIENTS-1:0]    cl_req_valid,
  input  logic [NUM_CLIENTS-1:0]    cl_req_write,
  input  logic [NUM_CLIENTS*32-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS*32-1:0] cl_req_handle,
  input  logic [NUM_CLIENTS*32-1:0] cl_req_data,
  output logic [NUM_CLIENTS-1:0]    cl_req_ready,
  output logic [NUM_CLIENTS-1:0]    cl_rsp_valid,
  output logic [31:0]               cl_rsp_data,
  input  logic [NUM_CLIENTS-1:0]    cl_rsp_ready,
  input  logic                      dma_rdy_readrequest,
  output logic                      dma_en_readrequest,
  output logic [31:0]               dma_readrequest_addr,
  output logic [31:0]               dma_readrequest_handle,
  input  logic                      dma_rdy_readresponse,
  input  logic [31:0]               dma_readresponse_data,
  output logic                      dma_en_readresponse,
  output logic                      dma_en_write32,
  output logic [31:0]               dma_write32_addr,
  output logic [31:0]               dma_write32_handle,
  output logic [31:0]               dma_write32_data,
  output logic                      busy,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  arb_state_t       state_r;
  arb_state_t       next_state_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] pick_idx_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic             pick_found_s;
  logic             accept_s;
  logic             rsp_fire_s;
  logic             owner_rsp_ready_s;
  dma_cmd_t         cmd_r;
  dma_cmd_t         pick_cmd_s;
  logic [31:0]      rd_count_r;
  logic [31:0]      wr_count_r;

  xsim_rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (cl_req_valid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Grants are suppressed while reset is held so nothing is accepted early.
  assign accept_s          = RST_N && (state_r == IDLE) && pick_found_s;
  assign owner_rsp_ready_s = cl_rsp_ready[owner_r];
  assign rsp_fire_s        = (state_r == RD_WAIT) && dma_rdy_readresponse && owner_rsp_ready_s;
  assign next_ptr_s        = (pick_idx_s == IDX_W'(NUM_CLIENTS - 1)) ? {IDX_W{1'b0}}
                                                                     : pick_idx_s + IDX_W'(1);

  // Select the winning client's command fields from the flat buses.
  always_comb begin
    pick_cmd_s = {$bits(dma_cmd_t){1'b0}};
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      pick_cmd_s = (pick_idx_s == IDX_W'(i))
                 ? {cl_req_write[i], cl_req_addr[32*i +: 32],
                    cl_req_handle[32*i +: 32], cl_req_data[32*i +: 32]}
                 : pick_cmd_s;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = ISSUE;
        else          next_state_s = IDLE;
      end
      ISSUE: begin
        if (cmd_r.write)              next_state_s = IDLE;
        else if (dma_rdy_readrequest) next_state_s = RD_WAIT;
        else                          next_state_s = ISSUE;
      end
      RD_WAIT: begin
        if (rsp_fire_s) next_state_s = IDLE;
        else            next_state_s = RD_WAIT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: grant pulse, engine strobes and response routing.
  always_comb begin
    cl_req_ready        = {NUM_CLIENTS{1'b0}};
    cl_rsp_valid        = {NUM_CLIENTS{1'b0}};
    dma_en_write32      = 1'b0;
    dma_en_readrequest  = 1'b0;
    dma_en_readresponse = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) cl_req_ready[pick_idx_s] = 1'b1;
        else          cl_req_ready = {NUM_CLIENTS{1'b0}};
      end
      ISSUE: begin
        if (cmd_r.write) dma_en_write32     = 1'b1;
        else             dma_en_readrequest = dma_rdy_readrequest;
      end
      RD_WAIT: begin
        cl_rsp_valid[owner_r] = dma_rdy_readresponse;
        dma_en_readresponse   = rsp_fire_s;
      end
      default: begin
        cl_req_ready = {NUM_CLIENTS{1'b0}};
      end
    endcase
  end

  // Latch the accepted command, advance the rotation and count traffic.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_r      <= {$bits(dma_cmd_t){1'b0}};
      owner_r    <= {IDX_W{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
      wr_count_r <= 32'd0;
      rd_count_r <= 32'd0;
    end else begin
      if (accept_s) begin
        cmd_r    <= pick_cmd_s;
        owner_r  <= pick_idx_s;
        rr_ptr_r <= next_ptr_s;
      end
      if ((state_r == ISSUE) && cmd_r.write) wr_count_r <= wr_count_r + 32'd1;
      if (rsp_fire_s)                        rd_count_r <= rd_count_r + 32'd1;
    end
  end

  assign busy                   = (state_r != IDLE);
  assign cl_rsp_data            = dma_readresponse_data;
  assign dma_readrequest_addr   = cmd_r.addr;
  assign dma_readrequest_handle = cmd_r.handle;
  assign dma_write32_addr       = cmd_r.addr;
  assign dma_write32_handle     = cmd_r.handle;
  assign dma_write32_data       = cmd_r.data;
  assign rd_count               = rd_count_r;
  assign wr_count               = wr_count_r;

endmodule

// File: tb/tb_xsim_dma_arbiter.sv
// Randomized and directed bench for xsim_dma_arbiter with a
// transaction-level reference model.
module tb_xsim_dma_arbiter;

  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [N-1:0]  cl_req_valid, cl_req_write, cl_req_ready, cl_rsp_valid, cl_rsp_ready;
  logic [N*32-1:0] cl_req_addr, cl_req_handle, cl_req_data;
  logic [31:0]   cl_rsp_data;
  logic          dma_rdy_readrequest, dma_en_readrequest;
  logic [31:0]   dma_readrequest_addr, dma_readrequest_handle;
  logic          dma_rdy_readresponse, dma_en_readresponse, dma_en_write32;
  logic [31:0]   dma_readresponse_data;
  logic [31:0]   dma_write32_addr, dma_write32_handle, dma_write32_data;
  logic          busy;
  logic [31:0]   rd_count, wr_count;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: rotation pointer and counters
  int          m_ptr = 0;
  logic [31:0] m_rd  = 32'd0;
  logic [31:0] m_wr  = 32'd0;

  // per-client command fields presented to the DUT
  logic [N-1:0] t_write;
  logic [31:0]  t_addr[N];
  logic [31:0]  t_handle[N];
  logic [31:0]  t_data[N];

  always #5 CLK = ~CLK;

  xsim_dma_arbiter #(.NUM_CLIENTS(N)) dut (
    .CLK                    (CLK),
    .RST_N                  (RST_N),
    .cl_req_valid           (cl_req_valid),
    .cl_req_write           (cl_req_write),
    .cl_req_addr            (cl_req_addr),
    .cl_req_handle          (cl_req_handle),
    .cl_req_data            (cl_req_data),
    .cl_req_ready           (cl_req_ready),
    .cl_rsp_valid           (cl_rsp_valid),
    .cl_rsp_data            (cl_rsp_data),
    .cl_rsp_ready           (cl_rsp_ready),
    .dma_rdy_readrequest    (dma_rdy_readrequest),
    .dma_en_readrequest     (dma_en_readrequest),
    .dma_readrequest_addr   (dma_readrequest_addr),
    .dma_readrequest_handle (dma_readrequest_handle),
    .dma_rdy_readresponse   (dma_rdy_readresponse),
    .dma_readresponse_data  (dma_readresponse_data),
    .dma_en_readresponse    (dma_en_readresponse),
    .dma_en_write32         (dma_en_write32),
    .dma_write32_addr       (dma_write32_addr),
    .dma_write32_handle     (dma_write32_handle),
    .dma_write32_data       (dma_write32_data),
    .busy                   (busy),
    .rd_count               (rd_count),
    .wr_count               (wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_req(input logic [N-1:0] vmask);
    cl_req_valid = vmask;
    cl_req_write = t_write;
    for (int i = 0; i < N; i++) begin
      cl_req_addr[32*i +: 32]   = t_addr[i];
      cl_req_handle[32*i +: 32] = t_handle[i];
      cl_req_data[32*i +: 32]   = t_data[i];
    end
  endtask

  task automatic rand_fields();
    t_write = 4'($urandom_range(0, 15));
    for (int i = 0; i < N; i++) begin
      t_addr[i]   = $urandom;
      t_handle[i] = $urandom;
      t_data[i]   = $urandom;
    end
  endtask

  // One transaction; called at posedge+1 with the DUT idle.
  task automatic run_txn(input logic [N-1:0] vmask, input int rq_stall, input int rsp_stall,
                         input logic [31:0] rdata, input bit abort);
    int          win;
    logic [N-1:0] own;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (win < 0 && vmask[c]) win = c;
    end
    own = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    drive_req(vmask);
    dma_rdy_readrequest  = 1'b0;
    dma_rdy_readresponse = 1'b0;
    cl_rsp_ready         = 4'($urandom_range(0, 15));
    @(negedge CLK);
    chk("grant", cl_req_ready, own);
    chk("idle_busy", busy, 1'b0);
    chk("idle_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b000);
    @(posedge CLK); #1;
    if (win < 0) return;
    m_ptr = (win + 1) % N;
    cl_req_valid = vmask & ~own;   // losers keep requesting while busy
    if (t_write[win]) begin
      @(negedge CLK);
      chk("wr_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b100);
      chk("wr_addr", dma_write32_addr, t_addr[win]);
      chk("wr_handle", dma_write32_handle, t_handle[win]);
      chk("wr_data", dma_write32_data, t_data[win]);
      chk("wr_no_grant", cl_req_ready, 4'b0000);
      m_wr = m_wr + 32'd1;
      @(posedge CLK); #1;
      chk("wr_count", wr_count, m_wr);
      cl_req_valid = 4'b0000;
    end else begin
      for (int s = 0; s < rq_stall; s++) begin
        @(negedge CLK);
        chk("rq_stall_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b000);
        chk("rq_stall_addr", dma_readrequest_addr, t_addr[win]);
        chk("rq_stall_busy", busy, 1'b1);
        chk("rq_stall_no_grant", cl_req_ready, 4'b0000);
        @(posedge CLK); #1;
      end
      dma_rdy_readrequest = 1'b1;
      @(negedge CLK);
      chk("rq_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b010);
      chk("rq_addr", dma_readrequest_addr, t_addr[win]);
      chk("rq_handle", dma_readrequest_handle, t_handle[win]);
      @(posedge CLK); #1;
      dma_rdy_readrequest   = 1'b0;
      dma_rdy_readresponse  = 1'b1;
      dma_readresponse_data = rdata;
      if (abort) begin
        cl_rsp_ready = ~own;
        @(negedge CLK);
        chk("abort_pre_valid", cl_rsp_valid, own);
        #1 RST_N = 1'b0;
        #1;
        chk("abort_rsp_valid", cl_rsp_valid, 4'b0000);
        chk("abort_busy", busy, 1'b0);
        chk("abort_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b000);
        chk("abort_rd_count", rd_count, 32'd0);
        chk("abort_wr_count", wr_count, 32'd0);
        chk("abort_addr", dma_readrequest_addr, 32'd0);
        cl_rsp_ready = 4'b1111;
        cl_req_valid = 4'b1111;
        @(negedge CLK);
        chk("in_reset_rsp_valid", cl_rsp_valid, 4'b0000);
        chk("in_reset_grant", cl_req_ready, 4'b0000);
        chk("in_reset_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b000);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        m_ptr = 0; m_rd = 32'd0; m_wr = 32'd0;
        cl_req_valid = 4'b0000; cl_rsp_ready = 4'b0000;
        dma_rdy_readresponse = 1'b0;
        @(negedge CLK);
        chk("post_reset_rd_count", rd_count, m_rd);
        chk("post_reset_busy", busy, 1'b0);
        @(posedge CLK); #1;
        return;
      end
      for (int s = 0; s < rsp_stall; s++) begin
        cl_rsp_ready = 4'($urandom_range(0, 15)) & ~own;
        @(negedge CLK);
        chk("rsp_stall_valid", cl_rsp_valid, own);
        chk("rsp_stall_data", cl_rsp_data, rdata);
        chk("rsp_stall_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b000);
        chk("rsp_stall_no_grant", cl_req_ready, 4'b0000);
        @(posedge CLK); #1;
      end
      cl_rsp_ready = 4'($urandom_range(0, 15)) | own;
      @(negedge CLK);
      chk("rsp_valid", cl_rsp_valid, own);
      chk("rsp_data", cl_rsp_data, rdata);
      chk("rsp_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b001);
      m_rd = m_rd + 32'd1;
      @(posedge CLK); #1;
      chk("rd_count", rd_count, m_rd);
      dma_rdy_readresponse = 1'b0;
      cl_rsp_ready = 4'b0000;
      cl_req_valid = 4'b0000;
    end
  endtask

  initial begin
    RST_N = 1'b1;
    dma_rdy_readrequest = 1'b0;
    dma_rdy_readresponse = 1'b0;
    dma_readresponse_data = 32'd0;
    cl_rsp_ready = 4'b0000;
    rand_fields();
    t_write[0] = 1'b1;
    drive_req(4'b0101);
    #2 RST_N = 1'b0;
    // reset held with clients 0 and 2 requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("rst_grant", cl_req_ready, 4'b0000);
      chk("rst_rsp_valid", cl_rsp_valid, 4'b0000);
      chk("rst_strobes", {dma_en_write32, dma_en_readrequest, dma_en_readresponse}, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_counts", {rd_count, wr_count}, 64'd0);
      chk("rst_wr_fields", {dma_write32_addr, dma_write32_data}, 64'd0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run_txn(4'b0101, 0, 0, 32'd0, 1'b0);          // client 0 first

    t_write[1] = 1'b1; t_addr[1] = 32'h40; t_handle[1] = 32'd3; t_data[1] = 32'hDEADBEEF;
    run_txn(4'b0010, 0, 0, 32'd0, 1'b0);

    t_write[3] = 1'b0; t_addr[3] = 32'h80;
    run_txn(4'b1000, 0, 0, 32'h12345678, 1'b0);

    rand_fields();
    t_write = 4'b1111;
    for (int r = 0; r < 5; r++) run_txn(4'b1111, 0, 0, 32'd0, 1'b0);  // 0,1,2,3,0

    t_write = 4'b1101;                             // client 1 reads, others write
    run_txn(4'b1111, 3, 2, 32'hA5A5_0F0F, 1'b0);

    t_write[2] = 1'b0;
    run_txn(4'b0100, 1, 0, 32'hCAFE_F00D, 1'b1);   // reset in RD_WAIT

    for (int r = 0; r < 40; r++) begin
      rand_fields();
      run_txn(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xsim_dma_arbiter.md
# xsim_dma_arbiter

Round-robin arbiter that shares the single simulated DMA read/write engine among `NUM_CLIENTS` requesters in the Xsim top level. It accepts one read or write32 command at a time from the clients and issues it to the engine. For reads it holds exactly one request outstanding and routes the returned word to the owning client. It also keeps read and write counters for the simulation log.

## Interface
- `NUM_CLIENTS`, 4, number of requesters (2..8)
- `IDX_W`, `$clog2(NUM_CLIENTS)`, client index width (derived, not overridden)
- `CLK` in 1: single clock, rising edge
- `RST_N` in 1: reset, asynchronous, active-low
- `cl_req_valid` in N: per-client command valid
- `cl_req_write` in N: 1 = write32, 0 = read
- `cl_req_addr` in N*32: per-client address, client i at bits [32i+31:32i]
- `cl_req_handle` in N*32: per-client memory handle
- `cl_req_data` in N*32: per-client write data (ignored for reads)
- `cl_req_ready` out N: one-hot accept pulse
- `cl_rsp_valid` out N: one-hot read-response valid
- `cl_rsp_data` out 32: read data, shared by all clients
- `cl_rsp_ready` in N: per-client response accept
- `dma_rdy_readrequest` in 1: engine can take a read
- `dma_en_readrequest` out 1: read issue strobe
- `dma_readrequest_addr`, `dma_readrequest_handle` out 32 each
- `dma_rdy_readresponse` in 1: engine holds read data
- `dma_readresponse_data` in 32: engine read data
- `dma_en_readresponse` out 1: consume engine read data
- `dma_en_write32` out 1: write strobe
- `dma_write32_addr`, `dma_write32_handle`, `dma_write32_data` out 32 each
- `busy` out 1: state != IDLE
- `rd_count`, `wr_count` out 32: completed reads and issued writes

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT. Registers: `state`, `rr_ptr`, `owner`, latched command {write, addr, handle, data}, counters.
- IDLE
  - Search clients starting at `rr_ptr` and wrapping modulo N. The first client with `cl_req_valid` high wins.
  - `cl_req_ready[winner]` = 1 in the same cycle (combinational from `cl_req_valid`).
  - Latch the command and `owner` = winner; set `rr_ptr` = (winner+1) mod N; go to ISSUE.
  - No valid client: stay in IDLE, all strobes 0.
- ISSUE, write
  - `dma_en_write32` = 1 for exactly this cycle with the latched fields.
  - `wr_count` += 1; go to IDLE.
- ISSUE, read
  - `dma_en_readrequest` = `dma_rdy_readrequest`, with the latched addr/handle.
  - If ready, go to RD_WAIT; otherwise hold in ISSUE with fields stable.
- RD_WAIT
  - `cl_rsp_valid[owner]` = `dma_rdy_readresponse`; `cl_rsp_data` = `dma_readresponse_data`.
  - When `cl_rsp_valid[owner]` and `cl_rsp_ready[owner]`: `dma_en_readresponse` = 1, `rd_count` += 1, go to IDLE.
- Only one transaction is in flight at any time. New requests are never accepted outside IDLE.
- Clients hold `cl_req_valid` and fields stable until accepted. A valid dropped before accept is simply not granted.
- `cl_rsp_ready` of non-owner clients is ignored. `cl_rsp_valid` of non-owners is 0.
- Counters wrap from 0xFFFFFFFF to 0.
- `dma_*` address, handle and data outputs are driven from the latched registers at all times. They are 0 after reset.

## Timing
- Reset (async assert, sync release on CLK), all to 0:
  - state = IDLE; `rr_ptr`, `owner`, latched command and counters = 0.
  - `cl_req_ready`, `cl_rsp_valid`, all `dma_en_*` and `busy` = 0.
- Reset during ISSUE or RD_WAIT drops the transaction. No strobe is emitted on or after reset. The engine is reset from the same source.
- Write accepted in cycle T: `dma_en_write32` at T+1; next accept at T+2 at the earliest.
- Read accepted in cycle T with the engine ready:
  - `dma_en_readrequest` at T+1.
  - Engine data valid at T+2, so `cl_rsp_valid` at T+2.
  - If `cl_rsp_ready` is high at T+2, `dma_en_readresponse` is at T+2 and the next accept is at T+3.
- Each cycle `dma_rdy_readrequest` is low in ISSUE adds one cycle. Each cycle the owner withholds `cl_rsp_ready` adds one cycle.
- All `dma_en_*` strobes are single-cycle and mutually exclusive.
- Fairness: with all clients continuously valid, grants rotate 0,1,..,N-1,0. No client waits more than N-1 grants.

## Structure
- Package `xsim_dma_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, RD_WAIT}
  - `dma_cmd_t` struct {logic write; logic [31:0] addr, handle, data}
  - `MAX_CLIENTS` = 8
- Sub-module `xsim_rr_pick`: combinational rotate-priority select. Takes N-bit request and `rr_ptr`; returns a `found` flag and the winner index.

## Test plan
- Reset with clients 0 and 2 holding valid: no ready, valid or strobe until `RST_N` rises. First grant goes to client 0, because `rr_ptr` = 0.
- Client 1 write, addr 0x40, handle 3, data 0xDEADBEEF: `cl_req_ready[1]` at T, then `dma_en_write32` at T+1 with those fields; `wr_count` = 1.
- Client 3 read, addr 0x80; engine returns 0x12345678: `cl_rsp_valid[3]` at T+2 with data 0x12345678, `dma_en_readresponse` in the same cycle, `rd_count` = 1, other `cl_rsp_valid` = 0.
- All 4 clients issue back-to-back writes: grant order is 0,1,2,3,0, with exactly one `dma_en_write32` every 2 cycles.
- Read with `dma_rdy_readrequest` low for 3 cycles and client `cl_rsp_ready` low for 2 cycles:
  - FSM holds with addr stable; exactly one `dma_en_readrequest` and one `dma_en_readresponse` are emitted.
  - No new grant is made while busy.
- `RST_N` asserted in RD_WAIT: outputs go to 0 immediately, the response is never delivered, and counters read 0.
